// File: rtl/mul_defs.sv
// Shared definitions for the multiplier job feeder: defaults, FSM encoding
// and the wait-counter width helper.
package mul_defs;

    localparam int W_DEF           = 4;
    localparam int DEPTH_DEF       = 4;
    localparam int MUL_LATENCY_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Wait counter must hold the value MUL_LATENCY itself.
    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/op_fifo.sv
// Operand FIFO with show-ahead head. Pointers carry one extra bit so that
// full and empty are distinguishable without a separate count.
module op_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    // Full is taken from registered pointers, so a pop in the same cycle
    // does not open a slot until the next cycle.
    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign rd_data   = r_mem[r_rptr[AW-1:0]];

    // Pointer update; push and pop may both happen in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mul_job_feeder.sv
// Job front-end for seq_mul: queues operand pairs, launches one multiply
// at a time, waits a fixed latency and holds the product on a valid/ready port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no job in flight; leave when the FIFO holds a pair
// ST_ISSUE | start pulse with operands on mul_a/mul_b; FIFO head popped
// ST_WAIT  | counting down the multiplier latency; capture op at count 1
// ST_HOLD  | result presented; wait for res_ready
module mul_job_feeder
    import mul_defs::*;
#(
    parameter int W           = W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           mul_start,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_op,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_data,
    output logic           busy
);
    localparam int CW = cnt_width(MUL_LATENCY);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_mul_start;
    logic [W-1:0]   r_mul_a;
    logic [W-1:0]   r_mul_b;
    logic           r_res_valid;
    logic [2*W-1:0] r_res_data;

    logic [2*W-1:0] w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;

    // in_ready is held low while reset is asserted so nothing is accepted.
    assign in_ready = rst_n & ~w_full;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_state == ST_ISSUE);
    assign busy     = (r_state != ST_IDLE) | ~w_empty;

    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

    op_fifo #(
        .DW    (2*W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data ({in_a, in_b}),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Job FSM with registered start/operand/result outputs. Operands are
    // loaded from the show-ahead head on entry to ISSUE so they are valid
    // during the start pulse; the head is popped at the end of ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state     <= ST_ISSUE;
                        r_mul_start <= 1'b1;
                        r_mul_a     <= w_head[2*W-1:W];
                        r_mul_b     <= w_head[W-1:0];
                    end
                end
                ST_ISSUE: begin
                    r_state     <= ST_WAIT;
                    r_mul_start <= 1'b0;
                    r_mul_a     <= '0;
                    r_mul_b     <= '0;
                    r_cnt       <= CW'(MUL_LATENCY);
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state     <= ST_HOLD;
                        r_res_data  <= mul_op;
                        r_res_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_job_feeder.md
# mul_job_feeder

Front-end stage for the sequential multiplier `seq_mul`: buffers incoming operand pairs in a small FIFO and launches one multiplication at a time. Each launch drives a one-cycle `start` pulse with the operands on `a`/`b`. The block waits a fixed latency, captures the product from `op`, and presents it downstream on a valid/ready result port. It replaces hand-driven `start`/`a`/`b` stimulus with a backpressure-aware job interface.

## Interface
- `W`, 4: operand width; product is 2W.
- `DEPTH`, 4: operand FIFO entries (power of two, ≥2).
- `MUL_LATENCY`, 5: cycles from the `start` cycle to the cycle in which `seq_mul.op` is valid.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO can accept; equals !full; 0 while `rst_n`=0.
- `in_a`, `in_b`  in  W  operands.
- `mul_start`  out  1  to `seq_mul.start`, one-cycle pulse.
- `mul_a`, `mul_b`  out  W  to `seq_mul.a`/`b`; operands during the pulse, 0 otherwise.
- `mul_op`  in  2W  from `seq_mul.op`.
- `res_valid`  out  1  product available.
- `res_ready`  in  1  downstream accepts.
- `res_data`  out  2W  captured product.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.

## Operation
- Push: `in_valid & in_ready` at a clock edge writes {in_a,in_b} to the FIFO.
- FSM states:
  - IDLE → ISSUE when the FIFO is non-empty (registered decision).
  - ISSUE: pop the head into the operand register; `mul_start`=1 with operands on `mul_a`/`mul_b`; load the wait counter with MUL_LATENCY; → WAIT.
  - WAIT: decrement each cycle. In the cycle where count reaches 1, sample `mul_op` into `res_data` at the edge; → HOLD.
  - HOLD: `res_valid`=1, `res_data` stable. `res_valid & res_ready` → IDLE.
- Only one job is in flight. `mul_start` is never reasserted before the previous result is consumed.
- Arithmetic is unsigned. `res_data` is `mul_op` verbatim; no checking or truncation.
- Full FIFO: `in_ready`=0. A pop in the same cycle does not free a slot until the next cycle.
- Empty FIFO in IDLE: stay in IDLE; `mul_start` stays 0.
- Push and pop in the same cycle with the FIFO not full: both occur, and occupancy is unchanged.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- Reset (also mid-job): FIFO emptied, FSM → IDLE, in-flight job dropped, any result not yet consumed is discarded. `seq_mul` has no reset, so its output is ignored until the next ISSUE.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after release; `mul_start`=0, `mul_a`=`mul_b`=0, `res_valid`=0, `res_data`=0, `busy`=0.
- Job timeline:
  - Push accepted at the edge ending cycle t, FSM idle, FIFO previously empty.
  - Cycle t+1: IDLE.
  - Cycle t+2: ISSUE, `mul_start`=1.
  - `mul_op` is sampled at the end of cycle t+2+MUL_LATENCY.
  - `res_valid`=1 from cycle t+3+MUL_LATENCY. With defaults, that is 8 cycles after the push.
- Back-to-back jobs: after a result handshake in cycle h, the next `mul_start` occurs in cycle h+2. Period is MUL_LATENCY+3 cycles with `res_ready` held high.
- `res_valid` deasserts in the cycle after the handshake. It never drops without a handshake except on reset.
- All outputs are registered except `in_ready` and `busy`, which are decoded from registered state.

## Structure
- Shared header/package `mul_defs`:
  - FSM state encoding (IDLE, ISSUE, WAIT, HOLD).
  - Default W, DEPTH, MUL_LATENCY.
  - Counter width, $clog2(MUL_LATENCY+1).
- Sub-module `op_fifo`:
  - Parameterised synchronous FIFO, 2W-bit wide and DEPTH deep, with sync active-low reset.
  - Ports push/pop/full/empty/rd_data, with show-ahead head.
- Top level holds the FSM, wait counter, operand register and result register.
- Verification instantiates `mul_job_feeder` connected to `seq_mul` on the same `clk`.

## Test plan
- Single job 5×9 (0101, 1001), `res_ready`=1 → `mul_start` one cycle with `mul_a`=5, `mul_b`=9; `res_data`=0x2D with `res_valid` 8 cycles after the push; one-cycle handshake.
- Stream 9×9, 15×15, 0×7, 1×1 with `res_ready`=1 → results 0x51, 0xE1, 0x00, 0x01 in order. Successive `mul_start` pulses are 8 cycles apart.
- Backpressure: 5×9 with `res_ready`=0 for 12 cycles → `res_valid`=1 and `res_data`=0x2D held steady, no further `mul_start`; releases on the first `res_ready`=1 cycle.
- FIFO full: `res_ready`=0, push 6 pairs back-to-back. Pair 1 issues; pairs 2–5 fill the FIFO; `in_ready`=0 at pair 6 so it is stalled, not lost. After release, all 6 products appear in order.
- Reset mid-WAIT: push 3×3, assert `rst_n`=0 for 2 cycles during WAIT → all outputs at reset values, no `res_valid`. A fresh job 2×7 afterwards yields 0x0E.
- Simultaneous push/pop: push in the same cycle as the ISSUE pop with 1 entry queued → occupancy stays 1, and both products are delivered.
